// File: rtl/seq_mul.sv
// Shift-and-add sequential multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Signed operands are multiplied as magnitudes and the result is negated at the end.
module seq_mul #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           dbg_state_o
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // in_ready is high only in IDLE and out_valid only in DONE, both decoded from state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;

   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   sum;
   logic [PW-1:0]    acc_step;

   // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
   always_comb begin
      abs_a = (is_signed && a[WIDTH-1]) ? ((~a) + WIDTH'(1)) : a;
      abs_b = (is_signed && b[WIDTH-1]) ? ((~b) + WIDTH'(1)) : b;
   end

   always_comb begin
      sum      = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      acc_step = {sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mcand_d  = abs_a;
               mplier_d = abs_b;
               neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               prod_d  = neg_q ? ((~acc_step) + PW'(1)) : acc_step;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
      end
   end

   assign product     = prod_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: expected products come from a behavioural multiply
// and are queued at accept, then popped when out_valid appears.
module tb_seq_mul;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           is_signed;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;
   logic [1:0]     dbg_state;

   logic [2*W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_mul #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .is_signed  (is_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .product    (product),
      .dbg_state_o(dbg_state)
   );

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
      logic signed [2*W-1:0] sx, sy;
      if (s) begin
         sx = {{W{x[W-1]}}, x};
         sy = {{W{y[W-1]}}, y};
         return sx * sy;
      end
      return {{W{1'b0}}, x} * {{W{1'b0}}, y};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // hold = number of DONE cycles with out_ready low; hold==0 keeps out_ready high throughout.
   task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input int hold);
      int lat;
      logic [2*W-1:0] exp;
      a         = x;
      b         = y;
      is_signed = s;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      exp_q.push_back(model(x, y, s));
      step();
      // junk operands offered while busy must be ignored
      a         = $urandom;
      b         = $urandom;
      is_signed = ~s;
      chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
      lat = 1;
      while (!out_valid && lat < 4 * W) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(W + 1));
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk({tag, "_prod"}, product, exp);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
         chk({tag, "_hold_prod"}, product, exp);
         chk({tag, "_hold_rdy"}, {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      step();
      // in_valid is still high here: the return edge must not also accept
      chk({tag, "_ret_rdy"}, {63'd0, in_ready}, 64'd1);
      chk({tag, "_ret_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_ret_state"}, {62'd0, dbg_state}, 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int pulses;
      logic [W-1:0] rx, ry;
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 32'd7;
      b         = 32'd9;
      is_signed = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_state", {62'd0, dbg_state}, 64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      chk("post_rst_idle", {62'd0, dbg_state}, 64'd0);

      run_mul("u3x5", 32'd3, 32'd5, 1'b0, 0);
      run_mul("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      run_mul("s_m7x3_bp", 32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 10);
      run_mul("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
      run_mul("s_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
      run_mul("u_min2", 32'h8000_0000, 32'h8000_0000, 1'b0, 2);
      run_mul("s_0xneg", 32'h0000_0000, 32'h8765_4321, 1'b1, 0);
      chk("lit_m7x3", model(32'hFFFF_FFF9, 32'h3, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);
      for (int i = 0; i < 4; i++) begin
         rx = $urandom;
         ry = $urandom;
         run_mul("rand", rx, ry, 1'(i % 2), $urandom_range(0, 3));
      end

      // abort mid-RUN: no product may follow
      a         = 32'd12345;
      b         = 32'd678;
      is_signed = 1'b0;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (15) step();
      chk("abort_in_run", {62'd0, dbg_state}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_product", product, 64'd0);
      pulses = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (out_valid) pulses++;
      end
      chk("abort_no_pulse", 64'(pulses), 64'd0);
      out_ready = 1'b0;
      run_mul("u2x2", 32'd2, 32'd2, 1'b0, 0);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-009 out_valid  output  1  product available.
REQ-010 out_ready  input  1  consumer takes product.
REQ-011 product  output  2*WIDTH  full-width product of accepted a*b.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept: in IDLE with in_valid=1, the block SHALL register a, b and is_signed and enter RUN with bit counter 0; otherwise it SHALL stay in IDLE.
REQ-015 At accept, signed mode: |a| and |b| SHALL be latched, plus a negate flag = a[MSB] XOR b[MSB]; unsigned mode: a and b SHALL be latched as-is, negate flag 0.
REQ-016 RUN SHALL process one multiplier bit (LSB first) per cycle: if the bit is 1, the multiplicand SHALL be added into the upper half of a 2*WIDTH accumulator using a WIDTH+1-bit add (carry kept), then the accumulator SHALL shift right by one.
REQ-017 RUN SHALL last exactly WIDTH cycles; no early termination on zero operands.
REQ-018 On the last RUN edge, the block SHALL enter DONE with product = accumulator, two's-complement negated when the negate flag is 1.
REQ-019 Latency: with the accept cycle as cycle 0, out_valid SHALL first be 1 in cycle WIDTH+1.
REQ-020 In DONE, product SHALL hold stable while out_ready=0 (backpressure, unbounded).
REQ-021 In DONE with out_ready=1, the block SHALL return to IDLE on that edge; a new operand pair SHALL NOT be accepted in the same cycle.
REQ-022 product arithmetic SHALL be exact modulo 2^(2*WIDTH); |-2^(WIDTH-1)| SHALL be handled as unsigned 2^(WIDTH-1) with no overflow.
REQ-023 Inputs a, b, is_signed and in_valid SHALL be ignored outside IDLE.
REQ-024 out_ready SHALL be ignored outside DONE.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL enter IDLE and clear accumulator, counter, operand registers and negate flag, regardless of state.
REQ-026 Reset values: in_ready=1, out_valid=0, product=0.
REQ-027 Reset mid-RUN or in DONE SHALL discard the operation in progress; no out_valid pulse SHALL follow it.
REQ-028 in_valid=1 during the reset cycle SHALL NOT be accepted.

Verification
REQ-029 Unsigned 3*5, out_ready=1 -> out_valid in cycle 33 after accept, product=0x000000000000000F, in_ready=1 next cycle.
REQ-030 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-031 Signed -7*3 (0xFFFFFFF9, 0x00000003) -> product=0xFFFFFFFFFFFFFFEB; signed -1*-1 -> 0x0000000000000001.
REQ-032 Signed 0x80000000*0x80000000 -> product=0x4000000000000000; unsigned same operands -> 0x4000000000000000.
REQ-033 Backpressure: out_ready=0 for 10 cycles after out_valid -> product and out_valid held, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst=1 in RUN cycle 16 of 12345*678 -> IDLE, in_ready=1, out_valid=0; a following 2*2 -> product=4 with normal latency.
